mem_arb: RTL and testbench
==========================

Name: mem_arb

Overview:
- N-port Avalon-MM arbiter in front of the single SRAM master port (sram_arb side). Each slave port can issue reads and writes; stimulus and check blocks attach as two of the N ports.
- Replaces the static read-before-write mux with registered arbitration that can run round-robin or fixed-priority.
- Grant lock holds the winning port until the memory accepts its transfer.
- Debug outputs show the current owner.

Parameters:
- ADDR_WIDTH, 20, address width of every port.
- DATA_WIDTH, 16, data width of every port.
- BE_WIDTH, DATA_WIDTH/8, byteenable width.
- NUM_PORTS, 2, number of slave ports; legal range 2..8.
- ARB_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin.
- PORT_W, $clog2(NUM_PORTS), width of the grant index.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- mem_address  out  ADDR_WIDTH  master address.
- mem_byteenable  out  BE_WIDTH  master byteenable.
- mem_read  out  1  master read strobe.
- mem_readdata  in  DATA_WIDTH  read data; valid in the cycle mem_waitrequest is low.
- mem_write  out  1  master write strobe.
- mem_writedata  out  DATA_WIDTH  master write data.
- mem_waitrequest  in  1  memory stall.
- s_address  in  NUM_PORTS*ADDR_WIDTH  per-port address, packed; port i uses slice i.
- s_byteenable  in  NUM_PORTS*BE_WIDTH  per-port byteenable, packed.
- s_read  in  NUM_PORTS  per-port read request.
- s_write  in  NUM_PORTS  per-port write request.
- s_writedata  in  NUM_PORTS*DATA_WIDTH  per-port write data, packed.
- s_readdata  out  DATA_WIDTH  mem_readdata broadcast to all ports.
- s_waitrequest  out  NUM_PORTS  per-port stall.
- grant_valid  out  1  a port currently owns the master.
- grant_id  out  PORT_W  index of the owning port.

Behaviour:
- Request definition: req[i] = s_read[i] | s_write[i].
- States:
  - IDLE: no owner.
  - OWN: grant_id owns the master.
- IDLE:
  - all s_waitrequest = 1; mem_read = mem_write = 0.
  - If any req, register the winner into grant_id, set grant_valid, go to OWN at the next edge.
  - Arbitration latency is therefore 1 cycle.
- OWN:
  - mem_address, mem_byteenable, mem_writedata, mem_read and mem_write are driven combinationally from port grant_id.
  - s_waitrequest[grant_id] = mem_waitrequest; every other port sees 1.
  - Transfer completes in the cycle where mem_waitrequest = 0 and the owner's read or write is high.
  - On completion: update the round-robin pointer to grant_id and clear grant_valid. If other requests are pending, re-arbitrate in that same cycle, registered, so back-to-back grants have no idle cycle. If nothing is pending, go to IDLE.
- Owner drops its request in OWN without completing: release to IDLE next cycle, pointer unchanged.
- Round-robin (ARB_MODE = 1):
  - Search starts at last_grant+1 and wraps modulo NUM_PORTS.
  - After NUM_PORTS-1 the search wraps to 0.
  - Pointer reset value is NUM_PORTS-1, so port 0 wins first after reset.
- Fixed priority (ARB_MODE = 0): lowest index with req wins; the pointer is ignored.
- s_read[i] and s_write[i] both high on the same port is a protocol violation.
  - The arbiter performs the read only; mem_write = 0.
  - The bench asserts this never happens.
- s_readdata is a pure pass-through of mem_readdata; the owner alone interprets it.
- Synchronous reset (reset_n low at a clock edge), including mid-transfer:
  - state -> IDLE, grant_valid = 0, grant_id = 0, pointer = NUM_PORTS-1.
  - Any in-flight transfer is abandoned.
  - Outputs are forced inactive combinationally while in IDLE: s_waitrequest all 1, mem_read = mem_write = 0, mem_address/mem_byteenable/mem_writedata = 0.
- No timeout. A memory that holds waitrequest high stalls the owner indefinitely while other ports wait.

Decomposition:
- Package mem_arb_pkg holds:
  - ARB_FIXED = 0 and ARB_RR = 1 mode constants.
  - state encoding for IDLE and OWN.
  - a function for packed-slice extraction.
- Sub-module mem_arb_pick: combinational rotate-priority picker.
  - Inputs: req[NUM_PORTS], last[PORT_W], mode.
  - Outputs: any, winner[PORT_W].
- mem_arb holds the state register, grant register, pointer and muxes.

Test Plan:
- Reset then port0 read: addr 0x00010, mem_waitrequest low after 2 cycles, readdata 0xBEEF. Required: grant_id = 0 one cycle after request; s_waitrequest[0] low exactly on the data cycle; port0 samples 0xBEEF.
- NUM_PORTS = 4, ARB_MODE = 1, all four ports request writes continuously with zero-wait memory. Required: grant order 0,1,2,3,0 with no idle cycle between grants; mem_writedata matches each port's value.
- ARB_MODE = 0, ports 1 and 3 requesting continuously. Required: port 1 served every time, port 3 never granted while port 1 requests.
- Port2 granted with mem_waitrequest held high for 5 cycles; port0 requests at cycle 1. Required: grant_id stays 2 until completion, then port0 is granted next cycle.
- reset_n pulsed low for 1 cycle mid-write. Required:
  - next cycle: grant_valid = 0, mem_write = 0, all s_waitrequest = 1.
  - first grant after reset goes to port 0 when ports 0 and 1 both request.
- Owner withdraws s_read before completion. Required: state returns to IDLE and pointer is unchanged, shown by the next winner under RR matching the pre-withdrawal order.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the mem_arb SRAM arbiter.
//   ARB_FIXED / ARB_RR : arbitration mode selectors (lowest index wins / rotating)
//   arb_state_e        : arbiter state encoding (no owner / a port owns the master)
//   getSlice           : pulls slice idx of a packed per-port bus, zero-extended
package mem_arb_pkg;

    localparam logic ARB_FIXED = 1'b0;
    localparam logic ARB_RR    = 1'b1;

    // Widest packed per-port bus getSlice can take (8 ports x 64 bits).
    localparam int SLICE_MAX = 512;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } arb_state_e;

    // Callers zero-extend their bus to SLICE_MAX and truncate the result back
    // to the field width, so one function serves address, data and byteenable.
    function automatic logic [SLICE_MAX-1:0] getSlice(
        input logic [SLICE_MAX-1:0] vec,
        input int                   idx,
        input int                   width
    );
        logic [SLICE_MAX-1:0] mask;
        mask = (SLICE_MAX'(1) << width) - SLICE_MAX'(1);
        return (vec >> (idx * width)) & mask;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational rotate-priority picker.
//   req_i    : per-port request vector
//   last_i   : most recently served port; the search starts just after it
//   mode_i   : ARB_RR rotates from last_i, ARB_FIXED always searches from 0
//   any_o    : at least one request present
//   winner_o : index of the selected port (0 when any_o is low)
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int PORT_W    = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [PORT_W-1:0]    last_i,
    input  logic                 mode_i,
    output logic                 any_o,
    output logic [PORT_W-1:0]    winner_o
);

    int base;
    int idx;

    // Fixed priority is the rotating search with the start pinned just after
    // the last port, which makes port 0 the first candidate.
    always_comb begin
        any_o    = 1'b0;
        winner_o = '0;
        idx      = 0;
        base     = (mode_i == ARB_RR) ? int'(last_i) : NUM_PORTS - 1;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            idx = (base + k) % NUM_PORTS;
            if (!any_o && req_i[PORT_W'(idx)]) begin
                any_o    = 1'b1;
                winner_o = PORT_W'(idx);
            end
        end
    end

endmodule

// File: rtl/mem_arb.sv
// N-port Avalon-MM arbiter in front of a single SRAM master port.
//   clock, reset_n       : rising-edge clock, synchronous active-low reset
//   mem_*                : master side toward the SRAM controller
//   s_*                  : packed per-port slave side (port i uses slice i)
//   s_readdata           : mem_readdata broadcast; only the owner consumes it
//   s_waitrequest        : per-port stall; only the owner sees the memory stall
//   grant_valid/grant_id : debug view of the current owner
// A registered grant holds the owning port until the memory accepts its
// transfer; the next owner is chosen in the completion cycle so back-to-back
// grants need no idle cycle.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 16,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int NUM_PORTS  = 2,
    parameter int ARB_MODE   = 1,
    parameter int PORT_W     = $clog2(NUM_PORTS)
) (
    input  logic                            clock,
    input  logic                            reset_n,
    output logic [ADDR_WIDTH-1:0]           mem_address,
    output logic [BE_WIDTH-1:0]             mem_byteenable,
    output logic                            mem_read,
    input  logic [DATA_WIDTH-1:0]           mem_readdata,
    output logic                            mem_write,
    output logic [DATA_WIDTH-1:0]           mem_writedata,
    input  logic                            mem_waitrequest,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] s_address,
    input  logic [NUM_PORTS*BE_WIDTH-1:0]   s_byteenable,
    input  logic [NUM_PORTS-1:0]            s_read,
    input  logic [NUM_PORTS-1:0]            s_write,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_writedata,
    output logic [DATA_WIDTH-1:0]           s_readdata,
    output logic [NUM_PORTS-1:0]            s_waitrequest,
    output logic                            grant_valid,
    output logic [PORT_W-1:0]               grant_id
);

    arb_state_e             state_q, state_d;
    logic [PORT_W-1:0]      grant_q, grant_d;
    logic [PORT_W-1:0]      pointer_q, pointer_d;

    logic [NUM_PORTS-1:0]   req;
    logic                   ownerRead;
    logic                   ownerWrite;
    logic                   ownerReq;
    logic                   xferDone;
    logic                   pickAny;
    logic [PORT_W-1:0]      pickWinner;
    logic [PORT_W-1:0]      pickLast;

    assign req        = s_read | s_write;
    assign ownerRead  = s_read[grant_q];
    assign ownerWrite = s_write[grant_q];
    assign ownerReq   = ownerRead | ownerWrite;
    assign xferDone   = (state_q == ST_OWN) && ownerReq && !mem_waitrequest;

    // On completion the pointer moves to the finishing owner in the same edge,
    // so the re-arbitration must already search from that owner.
    assign pickLast = xferDone ? grant_q : pointer_q;

    mem_arb_pick #(
        .NUM_PORTS (NUM_PORTS),
        .PORT_W    (PORT_W)
    ) u_pick (
        .req_i    (req),
        .last_i   (pickLast),
        .mode_i   ((ARB_MODE == 0) ? ARB_FIXED : ARB_RR),
        .any_o    (pickAny),
        .winner_o (pickWinner)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            pointer_q <= PORT_W'(NUM_PORTS - 1);
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            pointer_q <= pointer_d;
        end
    end

    // An owner that withdraws without completing is released without moving
    // the pointer, so it keeps its place in the rotation.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        pointer_d = pointer_q;
        case (state_q)
            ST_IDLE: begin
                if (pickAny) begin
                    state_d = ST_OWN;
                    grant_d = pickWinner;
                end
            end
            ST_OWN: begin
                if (!ownerReq) begin
                    state_d = ST_IDLE;
                end else if (xferDone) begin
                    pointer_d = grant_q;
                    if (pickAny) begin
                        grant_d = pickWinner;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read wins if a port raises both strobes, so the write is suppressed.
    always_comb begin
        mem_address    = '0;
        mem_byteenable = '0;
        mem_writedata  = '0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        s_waitrequest  = '1;
        if (state_q == ST_OWN) begin
            mem_address    = ADDR_WIDTH'(getSlice(SLICE_MAX'(s_address), int'(grant_q), ADDR_WIDTH));
            mem_byteenable = BE_WIDTH'(getSlice(SLICE_MAX'(s_byteenable), int'(grant_q), BE_WIDTH));
            mem_writedata  = DATA_WIDTH'(getSlice(SLICE_MAX'(s_writedata), int'(grant_q), DATA_WIDTH));
            mem_read       = ownerRead;
            mem_write      = ownerWrite & ~ownerRead;
            s_waitrequest[grant_q] = mem_waitrequest;
        end
    end

    assign s_readdata  = mem_readdata;
    assign grant_valid = (state_q == ST_OWN);
    assign grant_id    = grant_q;

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: a 4-port round-robin instance carries most
// scenarios, a 4-port fixed-priority instance on the same inputs covers the
// priority case. Completed transfers are matched against a queue of expected
// transfers filled as stimulus is driven.
module tb_mem_arb;

    localparam int AW = 20;
    localparam int DW = 16;
    localparam int BW = 2;
    localparam int NP = 4;
    localparam int PW = 2;

    typedef struct {
        int            port;
        logic          isWrite;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } expItem_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic [DW-1:0]    mem_readdata;
    logic             mem_waitrequest;
    logic [NP*AW-1:0] s_address;
    logic [NP*BW-1:0] s_byteenable;
    logic [NP-1:0]    s_read;
    logic [NP-1:0]    s_write;
    logic [NP*DW-1:0] s_writedata;

    logic [AW-1:0] memAddrA, memAddrB;
    logic [BW-1:0] memBeA, memBeB;
    logic          memReadA, memReadB;
    logic          memWriteA, memWriteB;
    logic [DW-1:0] memWdataA, memWdataB;
    logic [DW-1:0] sRdataA, sRdataB;
    logic [NP-1:0] sWaitA, sWaitB;
    logic          grantValidA, grantValidB;
    logic [PW-1:0] grantIdA, grantIdB;

    logic          sbSel = 1'b0;
    logic          monValid, monRead, monWrite;
    logic [PW-1:0] monId;
    logic [AW-1:0] monAddr;
    logic [DW-1:0] monWdata;

    expItem_t sbQ[$];
    expItem_t sbItem;
    int totalChecks = 0;
    int badChecks = 0;

    always #5 clock = ~clock;

    mem_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .NUM_PORTS(NP), .ARB_MODE(1), .PORT_W(PW)) dutRr (
        .clock(clock), .reset_n(reset_n),
        .mem_address(memAddrA), .mem_byteenable(memBeA), .mem_read(memReadA),
        .mem_readdata(mem_readdata), .mem_write(memWriteA), .mem_writedata(memWdataA),
        .mem_waitrequest(mem_waitrequest),
        .s_address(s_address), .s_byteenable(s_byteenable), .s_read(s_read),
        .s_write(s_write), .s_writedata(s_writedata), .s_readdata(sRdataA),
        .s_waitrequest(sWaitA), .grant_valid(grantValidA), .grant_id(grantIdA)
    );

    mem_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .NUM_PORTS(NP), .ARB_MODE(0), .PORT_W(PW)) dutFix (
        .clock(clock), .reset_n(reset_n),
        .mem_address(memAddrB), .mem_byteenable(memBeB), .mem_read(memReadB),
        .mem_readdata(mem_readdata), .mem_write(memWriteB), .mem_writedata(memWdataB),
        .mem_waitrequest(mem_waitrequest),
        .s_address(s_address), .s_byteenable(s_byteenable), .s_read(s_read),
        .s_write(s_write), .s_writedata(s_writedata), .s_readdata(sRdataB),
        .s_waitrequest(sWaitB), .grant_valid(grantValidB), .grant_id(grantIdB)
    );

    assign monValid = sbSel ? grantValidB : grantValidA;
    assign monRead  = sbSel ? memReadB : memReadA;
    assign monWrite = sbSel ? memWriteB : memWriteA;
    assign monId    = sbSel ? grantIdB : grantIdA;
    assign monAddr  = sbSel ? memAddrB : memAddrA;
    assign monWdata = sbSel ? memWdataB : memWdataA;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        totalChecks++;
        if (got !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] port, input logic rd, input logic wr,
                                 input logic [AW-1:0] addr, input logic [DW-1:0] data);
        s_read[port]                      = rd;
        s_write[port]                     = wr;
        s_address[int'(port)*AW +: AW]    = addr;
        s_writedata[int'(port)*DW +: DW]  = data;
        s_byteenable[int'(port)*BW +: BW] = '1;
    endtask

    task automatic pushExp(input int port, input logic isWrite, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        expItem_t e;
        e.port = port;
        e.isWrite = isWrite;
        e.addr = addr;
        e.data = data;
        sbQ.push_back(e);
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic doReset();
        s_read = '0;
        s_write = '0;
        s_address = '0;
        s_byteenable = '0;
        s_writedata = '0;
        mem_waitrequest = 1'b1;
        mem_readdata = '0;
        reset_n = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    // Every accepted transfer on the monitored instance must match the oldest
    // expected transfer.
    always @(negedge clock) begin
        if (reset_n && monValid && (monRead || monWrite) && !mem_waitrequest) begin
            checkOutput("sbPending", 32'(sbQ.size() != 0), 32'd1);
            if (sbQ.size() != 0) begin
                sbItem = sbQ.pop_front();
                checkOutput("sbPort", 32'(monId), 32'(sbItem.port));
                checkOutput("sbIsWrite", 32'(monWrite), 32'(sbItem.isWrite));
                checkOutput("sbAddr", 32'(monAddr), 32'(sbItem.addr));
                checkOutput("sbData", 32'(sbItem.isWrite ? monWdata : sRdataA), 32'(sbItem.data));
            end
        end
    end

    always @(posedge clock) begin
        if (reset_n) begin
            assert ((s_read & s_write) == '0)
            else $error("[TB] port drove read and write together");
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not end in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit found;

        // Reset state, then a single read with two stall cycles.
        doReset();
        @(negedge clock);
        checkOutput("rstValid", 32'(grantValidA), 32'd0);
        checkOutput("rstId", 32'(grantIdA), 32'd0);
        checkOutput("rstWait", 32'(sWaitA), 32'hF);
        checkOutput("rstStrobes", 32'({memReadA, memWriteA}), 32'd0);
        checkOutput("rstAddr", 32'(memAddrA), 32'd0);
        nextCycle();
        pushExp(0, 1'b0, 20'h00010, 16'hBEEF);
        applyStimulus(2'd0, 1'b1, 1'b0, 20'h00010, 16'h0000);
        nextCycle();
        @(negedge clock);
        checkOutput("t1Valid", 32'(grantValidA), 32'd1);
        checkOutput("t1Id", 32'(grantIdA), 32'd0);
        checkOutput("t1Read", 32'(memReadA), 32'd1);
        checkOutput("t1Addr", 32'(memAddrA), 32'h00010);
        checkOutput("t1Be", 32'(memBeA), 32'h3);
        checkOutput("t1Stall1", 32'(sWaitA[0]), 32'd1);
        nextCycle();
        @(negedge clock);
        checkOutput("t1Stall2", 32'(sWaitA[0]), 32'd1);
        nextCycle();
        mem_waitrequest = 1'b0;
        mem_readdata = 16'hBEEF;
        @(negedge clock);
        checkOutput("t1WaitLow", 32'(sWaitA[0]), 32'd0);
        checkOutput("t1Rdata", 32'(sRdataA), 32'hBEEF);
        nextCycle();
        applyStimulus(2'd0, 1'b0, 1'b0, 20'h0, 16'h0);
        mem_waitrequest = 1'b1;
        nextCycle();
        nextCycle();

        // Round-robin: four continuous writers, zero-wait memory.
        doReset();
        mem_waitrequest = 1'b0;
        for (int i = 0; i < NP; i++)
            applyStimulus(2'(i), 1'b0, 1'b1, AW'(32'h100 + i), DW'(32'hA000 + i));
        for (int k = 0; k < 5; k++)
            pushExp(k % NP, 1'b1, AW'(32'h100 + k % NP), DW'(32'hA000 + k % NP));
        for (int k = 0; k < 5; k++) begin
            nextCycle();
            @(negedge clock);
            checkOutput("rrValid", 32'(grantValidA), 32'd1);
            checkOutput("rrId", 32'(grantIdA), 32'(k % NP));
            checkOutput("rrWdata", 32'(memWdataA), 32'hA000 + 32'(k % NP));
        end
        nextCycle();
        s_write = '0;
        mem_waitrequest = 1'b1;
        nextCycle();
        nextCycle();

        // Fixed priority: ports 1 and 3 continuous, port 1 always wins.
        sbSel = 1'b1;
        doReset();
        mem_waitrequest = 1'b0;
        applyStimulus(2'd1, 1'b0, 1'b1, 20'h00111, 16'h1111);
        applyStimulus(2'd3, 1'b0, 1'b1, 20'h00333, 16'h3333);
        for (int k = 0; k < 4; k++)
            pushExp(1, 1'b1, 20'h00111, 16'h1111);
        pushExp(3, 1'b1, 20'h00333, 16'h3333);
        for (int k = 0; k < 4; k++) begin
            nextCycle();
            @(negedge clock);
            checkOutput("fxValid", 32'(grantValidB), 32'd1);
            checkOutput("fxId", 32'(grantIdB), 32'd1);
        end
        nextCycle();
        applyStimulus(2'd1, 1'b0, 1'b0, 20'h0, 16'h0);
        found = 1'b0;
        for (int w = 0; w < 8 && !found; w++) begin
            nextCycle();
            @(negedge clock);
            if (grantValidB && grantIdB == 2'd3)
                found = 1'b1;
        end
        checkOutput("fxPort3Granted", 32'(found), 32'd1);
        nextCycle();
        s_write = '0;
        mem_waitrequest = 1'b1;
        nextCycle();
        nextCycle();
        sbSel = 1'b0;

        // Grant lock: port 2 stalled five cycles while port 0 waits.
        doReset();
        applyStimulus(2'd2, 1'b0, 1'b1, 20'h00222, 16'h2222);
        pushExp(2, 1'b1, 20'h00222, 16'h2222);
        pushExp(0, 1'b1, 20'h00200, 16'h0A0A);
        nextCycle();
        applyStimulus(2'd0, 1'b0, 1'b1, 20'h00200, 16'h0A0A);
        @(negedge clock);
        checkOutput("stId", 32'(grantIdA), 32'd2);
        checkOutput("stWait", 32'(sWaitA), 32'hF);
        for (int k = 2; k <= 5; k++) begin
            nextCycle();
            @(negedge clock);
            checkOutput("stId", 32'(grantIdA), 32'd2);
            checkOutput("stWait", 32'(sWaitA), 32'hF);
        end
        nextCycle();
        mem_waitrequest = 1'b0;
        @(negedge clock);
        checkOutput("stDoneId", 32'(grantIdA), 32'd2);
        checkOutput("stDoneWait", 32'(sWaitA), 32'hB);
        nextCycle();
        applyStimulus(2'd2, 1'b0, 1'b0, 20'h0, 16'h0);
        @(negedge clock);
        checkOutput("stNextValid", 32'(grantValidA), 32'd1);
        checkOutput("stNextId", 32'(grantIdA), 32'd0);
        nextCycle();
        s_write = '0;
        mem_waitrequest = 1'b1;
        nextCycle();
        nextCycle();

        // Reset mid-write after the pointer has moved off its reset value.
        doReset();
        mem_waitrequest = 1'b0;
        applyStimulus(2'd0, 1'b0, 1'b1, 20'h00300, 16'h3030);
        pushExp(0, 1'b1, 20'h00300, 16'h3030);
        nextCycle();
        nextCycle();
        applyStimulus(2'd0, 1'b0, 1'b0, 20'h0, 16'h0);
        applyStimulus(2'd1, 1'b0, 1'b1, 20'h00311, 16'h3131);
        mem_waitrequest = 1'b1;
        nextCycle();
        nextCycle();
        @(negedge clock);
        checkOutput("rsPreId", 32'(grantIdA), 32'd1);
        checkOutput("rsPreWrite", 32'(memWriteA), 32'd1);
        nextCycle();
        reset_n = 1'b0;
        nextCycle();
        reset_n = 1'b1;
        applyStimulus(2'd0, 1'b0, 1'b1, 20'h00301, 16'h3232);
        @(negedge clock);
        checkOutput("rsValid", 32'(grantValidA), 32'd0);
        checkOutput("rsWrite", 32'(memWriteA), 32'd0);
        checkOutput("rsWait", 32'(sWaitA), 32'hF);
        checkOutput("rsIdZero", 32'(grantIdA), 32'd0);
        nextCycle();
        @(negedge clock);
        checkOutput("rsFirstValid", 32'(grantValidA), 32'd1);
        checkOutput("rsFirstId", 32'(grantIdA), 32'd0);
        nextCycle();
        s_write = '0;
        nextCycle();
        nextCycle();

        // Owner withdraws: pointer must stay, so port 0 still wins next.
        doReset();
        applyStimulus(2'd0, 1'b1, 1'b0, 20'h00600, 16'h0);
        nextCycle();
        @(negedge clock);
        checkOutput("wdId", 32'(grantIdA), 32'd0);
        checkOutput("wdValid", 32'(grantValidA), 32'd1);
        nextCycle();
        applyStimulus(2'd0, 1'b0, 1'b0, 20'h0, 16'h0);
        applyStimulus(2'd1, 1'b1, 1'b0, 20'h00611, 16'h0);
        nextCycle();
        applyStimulus(2'd0, 1'b1, 1'b0, 20'h00600, 16'h0);
        @(negedge clock);
        checkOutput("wdIdle", 32'(grantValidA), 32'd0);
        nextCycle();
        mem_waitrequest = 1'b0;
        mem_readdata = 16'h600D;
        pushExp(0, 1'b0, 20'h00600, 16'h600D);
        @(negedge clock);
        checkOutput("wdNextId", 32'(grantIdA), 32'd0);
        nextCycle();
        applyStimulus(2'd0, 1'b0, 1'b0, 20'h0, 16'h0);
        mem_readdata = 16'h0ACE;
        pushExp(1, 1'b0, 20'h00611, 16'h0ACE);
        @(negedge clock);
        checkOutput("wdThenId", 32'(grantIdA), 32'd1);
        nextCycle();
        s_read = '0;
        mem_waitrequest = 1'b1;
        nextCycle();
        nextCycle();

        checkOutput("sbDrained", 32'(sbQ.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
